alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/alu_rr_arb.sv | 17 +
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RES_W  = 9;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned N_REQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_PASS_A = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD    = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0010;
  localparam logic [OP_W-1:0] OP_INC    = 4'b0011;
  localparam logic [OP_W-1:0] OP_DEC    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SHL    = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHR    = 4'b0110;
  localparam logic [OP_W-1:0] OP_ROL    = 4'b0111;
  localparam logic [OP_W-1:0] OP_OR     = 4'b1000;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b1001;
  localparam logic [OP_W-1:0] OP_AND    = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOT_A  = 4'b1011;
  localparam logic [OP_W-1:0] OP_MAX    = OP_NOT_A;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module alu_rr_arb
  import alu_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             last_i,
  output logic [N_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external 8-bit ALU between two requesters, one command in flight.
module alu_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_result,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt;

  alu_rr_arb u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake decode; rst masks handshakes within its own cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          id_d    = gnt[1];
          last_d  = gnt[1];
          a_d     = gnt[1] ? req_a1  : req_a0;
          b_d     = gnt[1] ? req_b1  : req_b0;
          op_d    = gnt[1] ? req_op1 : req_op0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_d   = op_legal(op_q) ? alu_result : '0;
        err_d   = !op_legal(op_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and cycle model.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_a0, req_b0, req_a1, req_b1, alu_a, alu_b;
  logic [3:0]  req_op0, req_op1, alu_op;
  logic [8:0]  alu_result, rsp_result;
  logic        rsp_err, busy;
  logic [15:0] op_count;

  int n_checks = 0, n_pass = 0;
  int m_state = 0;
  logic m_id = 1'b0, exp_last = 1'b1, acc_id = 1'b0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_op = '0;
  logic [15:0] exp_cnt = '0;
  logic [8:0] sb_res[$];
  logic       sb_err[$];
  logic [8:0] done_res[$];
  logic       done_err[$];
  logic       done_id[$];
  int n_acc = 0, n_done = 0, acc_cyc = 0, done_cyc = 0, cyc_n = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
    case (op)
      OP_PASS_A: return {1'b0, a};
      OP_ADD:    return {1'b0, a} + {1'b0, b};
      OP_SUB:    return {1'b0, a} - {1'b0, b};
      OP_INC:    return {1'b0, a} + 9'd1;
      OP_DEC:    return {1'b0, a} - 9'd1;
      OP_SHL:    return {a, 1'b0};
      OP_SHR:    return {a[0], 1'b0, a[7:1]};
      OP_ROL:    return {a[7], a[6:0], a[7]};
      OP_OR:     return {1'b0, a | b};
      OP_XOR:    return {1'b0, a ^ b};
      OP_AND:    return {1'b0, a & b};
      OP_NOT_A:  return {1'b0, ~a};
      default:   return 9'h1FF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  function automatic logic [1:0] rr_model(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle model evaluated once per negative edge, ahead of the next rising edge.
  task automatic monitor();
    logic [1:0] g;
    logic       id;
    logic [3:0] op;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      m_state = 0; exp_last = 1'b1; exp_cnt = '0;
      m_a = '0; m_b = '0; m_op = '0;
      sb_res.delete(); sb_err.delete();
    end else begin
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("busy", 32'(busy), 32'(m_state != 0));
      case (m_state)
        0: begin
          g = rr_model(req_valid, exp_last);
          chk("req_ready", 32'(req_ready), 32'(g));
          chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
          if (g != 2'b00) begin
            id = g[1];
            m_a = id ? req_a1 : req_a0;
            m_b = id ? req_b1 : req_b0;
            op  = id ? req_op1 : req_op0;
            m_op = op;
            sb_res.push_back((op > OP_MAX) ? 9'h000 : alu_model(m_a, m_b, op));
            sb_err.push_back(op > OP_MAX);
            exp_last = id; m_id = id; acc_id = id;
            n_acc++; acc_cyc = cyc_n; m_state = 1;
          end
        end
        1: begin
          chk("issue_req_ready", 32'(req_ready), 32'd0);
          chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
          m_state = 2;
        end
        default: begin
          chk("resp_req_ready", 32'(req_ready), 32'd0);
          chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << m_id));
          if (rsp_ready[m_id]) begin
            if (sb_res.size() == 0) begin
              chk("sb_underflow", 32'd1, 32'd0);
            end else begin
              chk("rsp_result", 32'(rsp_result), 32'(sb_res.pop_front()));
              chk("rsp_err", 32'(rsp_err), 32'(sb_err.pop_front()));
            end
            done_res.push_back(rsp_result);
            done_err.push_back(rsp_err);
            done_id.push_back(m_id);
            exp_cnt = exp_cnt + 16'd1;
            n_done++; done_cyc = cyc_n; m_state = 0;
          end
        end
      endcase
    end
    cyc_n++;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int s);
    for (int i = 0; i < 16 && n_acc == s; i++) cyc();
    if (n_acc == s) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int p);
    int s;
    s = n_acc;
    req_valid[p] = 1'b1;
    wait_accept(s);
    req_valid = 2'b00;
  endtask

  task automatic wait_done();
    int s;
    s = n_done;
    for (int i = 0; i < 32 && n_done == s; i++) cyc();
    if (n_done == s) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_port(input int p, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op);
    if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
  endtask

  initial begin
    int d0, seen;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    set_port(0, 8'h00, 8'h00, 4'h0);
    set_port(1, 8'h00, 8'h00, 4'h0);
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0; req_valid = 2'b00;
    cyc();
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request with latency check
    rsp_ready = 2'b11;
    set_port(0, 8'hFF, 8'h01, OP_ADD);
    send(0);
    wait_done();
    chk("t1_id", 32'(done_id[$]), 32'd0);
    chk("t1_result", 32'(done_res[$]), 32'h100);
    chk("t1_err", 32'(done_err[$]), 32'd0);
    chk("t1_latency", 32'(done_cyc - acc_cyc), 32'd2);
    chk("t1_op_count", 32'(op_count), 32'd1);
    chk("t1_alu_hold", 32'(alu_a), 32'hFF);

    // Simultaneous requests after reset
    rst = 1'b1; cyc(); rst = 1'b0;
    set_port(0, 8'h05, 8'h07, OP_SUB);
    set_port(1, 8'hF0, 8'h3C, OP_AND);
    req_valid = 2'b11;
    d0 = done_res.size(); seen = n_acc;
    for (int i = 0; i < 40 && done_res.size() < d0 + 2; i++) begin
      cyc();
      if (n_acc != seen) begin req_valid[acc_id] = 1'b0; seen = n_acc; end
    end
    req_valid = 2'b00;
    chk("t2_count", 32'(done_res.size()), 32'(d0 + 2));
    if (done_res.size() >= d0 + 2) begin
      chk("t2_first_id", 32'(done_id[d0]), 32'd0);
      chk("t2_first_res", 32'(done_res[d0]), 32'h1FE);
      chk("t2_second_id", 32'(done_id[d0+1]), 32'd1);
      chk("t2_second_res", 32'(done_res[d0+1]), 32'h030);
    end

    // Backpressure; rsp_ready on the other bit must be ignored
    rsp_ready = 2'b01;
    set_port(1, 8'h5A, 8'hFF, OP_XOR);
    send(1);
    set_port(0, 8'h03, 8'h04, OP_ADD);
    req_valid = 2'b01;
    for (int i = 0; i < 8 && rsp_valid == 2'b00; i++) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t3_rsp_result", 32'(rsp_result), 32'h0A5);
      chk("t3_rsp_err", 32'(rsp_err), 32'd0);
      chk("t3_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b10;
    wait_done();
    rsp_ready = 2'b11;
    wait_accept(n_acc);
    req_valid = 2'b00;
    wait_done();
    chk("t3_port0_res", 32'(done_res[$]), 32'h007);

    // Illegal opcode
    set_port(0, 8'h12, 8'h34, 4'hF);
    send(0);
    wait_done();
    chk("t4_result", 32'(done_res[$]), 32'h000);
    chk("t4_err", 32'(done_err[$]), 32'd1);
    chk("t4_op_count", 32'(op_count), 32'd5);

    // Reset while in RESP aborts the transaction
    rsp_ready = 2'b00;
    set_port(0, 8'h01, 8'h01, OP_ADD);
    send(0);
    for (int i = 0; i < 8 && rsp_valid == 2'b00; i++) cyc();
    chk("t5_in_resp", 32'(rsp_valid), 32'h1);
    rst = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11;
    #1;
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0; req_valid = 2'b00;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd0);
    set_port(1, 8'h10, 8'h20, OP_ADD);
    send(1);
    wait_done();
    chk("t5_new_res", 32'(done_res[$]), 32'h030);
    chk("t5_new_id", 32'(done_id[$]), 32'd1);
    chk("t5_new_count", 32'(op_count), 32'd1);

    // Counter wrap
    force dut.cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    cyc();
    release dut.cnt_q;
    chk("t6_preload", 32'(op_count), 32'hFFFF);
    set_port(0, 8'h77, 8'h00, OP_PASS_A);
    send(0);
    wait_done();
    chk("t6_wrap", 32'(op_count), 32'd0);
    chk("t6_res", 32'(done_res[$]), 32'h077);

    // Random traffic, including requests withdrawn before acceptance
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      set_port(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      set_port(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      cyc();
    end
    chk("rand_progress", 32'(n_done > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
